// File: rtl/twofish_iter_ctrl_if.sv
// Plaintext/key request and ciphertext response handshake for twofish_iter_ctrl.
interface twofish_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_text;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_text;

  modport master (
    output in_valid, in_text, in_key, out_ready,
    input  in_ready, out_valid, out_text
  );

  modport slave (
    input  in_valid, in_text, in_key, out_ready,
    output in_ready, out_valid, out_text
  );
endinterface

// File: rtl/twofish_iter_ctrl.sv
// Iterative Twofish encrypt sequencer: whitening in-house, rounds on one shared external round unit.
// Build option TWOFISH_FINAL_SWAP_EN: the last round loads un-swapped (Twofish reference ordering).
module twofish_iter_ctrl #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                clk,
  input  logic                rst,
  twofish_iter_ctrl_if.slave  bus,
  output logic                busy,
  output logic [127:0]        key_q,
  output logic [4:0]          sk_sel,
  input  logic [31:0]         sk0,
  input  logic [31:0]         sk1,
  output logic                rnd_en,
  output logic [31:0]         rnd_r0,
  output logic [31:0]         rnd_r1,
  output logic [31:0]         rnd_r2,
  output logic [31:0]         rnd_r3,
  input  logic [31:0]         rnd_c2,
  input  logic [31:0]         rnd_c3,
  input  logic [31:0]         rnd_o0,
  input  logic [31:0]         rnd_o1
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IWH0  = 3'd1,
    IWH1  = 3'd2,
    ROUND = 3'd3,
    OWH0  = 3'd4,
    OWH1  = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [4:0] LAST_CNT = 5'(NUM_ROUNDS - 1);

  state_t       state_q, state_d;
  logic [31:0]  s0_q, s1_q, s2_q, s3_q;
  logic [31:0]  s0_d, s1_d, s2_d, s3_d;
  logic [127:0] key_d;
  logic [4:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      key_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    sk_sel  = 5'd0;
    rnd_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          {s0_d, s1_d, s2_d, s3_d} = bus.in_text;
          key_d   = bus.in_key;
          state_d = IWH0;
        end
      end
      IWH0: begin
        sk_sel  = 5'd0;
        s0_d    = s0_q ^ sk0;
        s1_d    = s1_q ^ sk1;
        state_d = IWH1;
      end
      IWH1: begin
        sk_sel  = 5'd1;
        s2_d    = s2_q ^ sk0;
        s3_d    = s3_q ^ sk1;
        cnt_d   = 5'd0;
        state_d = ROUND;
      end
      ROUND: begin
        sk_sel = 5'd4 + cnt_q;
        rnd_en = 1'b1;
        {s0_d, s1_d, s2_d, s3_d} = {rnd_c2, rnd_c3, rnd_o0, rnd_o1};
        if (cnt_q == LAST_CNT) begin
`ifdef TWOFISH_FINAL_SWAP_EN
          {s0_d, s1_d, s2_d, s3_d} = {rnd_o0, rnd_o1, rnd_c2, rnd_c3};
`endif
          // Park the counter at 0 rather than letting it run past the last round.
          cnt_d   = 5'd0;
          state_d = OWH0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      OWH0: begin
        sk_sel  = 5'd2;
        s0_d    = s0_q ^ sk0;
        s1_d    = s1_q ^ sk1;
        state_d = OWH1;
      end
      OWH1: begin
        sk_sel  = 5'd3;
        s2_d    = s2_q ^ sk0;
        s3_d    = s3_q ^ sk1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_text  = {s0_q, s1_q, s2_q, s3_q};
  assign busy          = (state_q != IDLE);
  assign rnd_r0        = s0_q;
  assign rnd_r1        = s1_q;
  assign rnd_r2        = s2_q;
  assign rnd_r3        = s3_q;

endmodule

// File: tb/tb_twofish_iter_ctrl.sv
// Self-checking bench for twofish_iter_ctrl: stubbed round unit / key schedule, transaction-level model.
module tb_twofish_iter_ctrl;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         busy;
  logic [127:0] key_q;
  logic [4:0]   sk_sel;
  logic [31:0]  sk0, sk1;
  logic         rnd_en;
  logic [31:0]  rnd_r0, rnd_r1, rnd_r2, rnd_r3;
  logic [31:0]  rnd_c2, rnd_c3, rnd_o0, rnd_o1;

  int n_checks = 0;
  int n_fail   = 0;
  int ks_mode  = 0;   // 0 zero, 1 A5 on pairs 0..3, 2 A5 on 0..1 / FF on 2..3, 3 key hash
  int rnd_mode = 0;   // 0 pure swap, 1 mixing round

  twofish_iter_ctrl_if bus();

  twofish_iter_ctrl #(.NUM_ROUNDS(N)) dut (
    .clk(clk), .rst(rst), .bus(bus), .busy(busy), .key_q(key_q),
    .sk_sel(sk_sel), .sk0(sk0), .sk1(sk1), .rnd_en(rnd_en),
    .rnd_r0(rnd_r0), .rnd_r1(rnd_r1), .rnd_r2(rnd_r2), .rnd_r3(rnd_r3),
    .rnd_c2(rnd_c2), .rnd_c3(rnd_c3), .rnd_o0(rnd_o0), .rnd_o1(rnd_o1)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ks(input logic [127:0] key, input int idx, input int mode);
    logic [31:0] i32;
    i32 = 32'(idx);
    case (mode)
      1: ks = (idx < 4) ? {2{32'hA5A5A5A5}} : 64'h0;
      2: ks = (idx < 2) ? {2{32'hA5A5A5A5}} : (idx < 4) ? {2{32'hFFFFFFFF}} : 64'h0;
      3: ks = {key[127:96] ^ (i32 * 32'h9E3779B9), key[63:32] ^ key[31:0] ^ (i32 * 32'h7F4A7C15)};
      default: ks = 64'h0;
    endcase
  endfunction

  // Returns {c2, c3, r0, r1} for round inputs {R0, R1, R2, R3} = r.
  function automatic logic [127:0] rnd_f(input logic [127:0] r, input logic [63:0] k, input int mode);
    logic [31:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = r;
    if (mode == 1)
      rnd_f = {a2 ^ a0 ^ k[63:32], {a3[30:0], a3[31]} ^ a1 ^ k[31:0], ~a0, a1 ^ k[63:32]};
    else
      rnd_f = {a2, a3, a0, a1};
  endfunction

  function automatic logic [127:0] model_ct(input logic [127:0] text, input logic [127:0] key,
                                            input int km, input int rm);
    logic [127:0] s, o;
    s = text;
    s[127:64] ^= ks(key, 0, km);
    s[63:0]   ^= ks(key, 1, km);
    for (int r = 0; r < N; r++) begin
      o = rnd_f(s, ks(key, 4 + r, km), rm);
      s = o;
`ifdef TWOFISH_FINAL_SWAP_EN
      if (r == N - 1) s = {o[63:0], o[127:64]};
`endif
    end
    s[127:64] ^= ks(key, 2, km);
    s[63:0]   ^= ks(key, 3, km);
    model_ct = s;
  endfunction

  // Environment stubs: key schedule addressed by sk_sel, round unit fed by state words and subkeys.
  always_comb begin
    logic [63:0] tk;
    tk = ks(key_q, int'(sk_sel), ks_mode);
    {sk0, sk1} = tk;
    {rnd_c2, rnd_c3, rnd_o0, rnd_o1} = rnd_f({rnd_r0, rnd_r1, rnd_r2, rnd_r3}, tk, rnd_mode);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting on DUT", nm);
  endtask

  // Transaction model: cycles since accept, expected ciphertext, expected latched key.
  bit           m_busy = 0;
  bit           m_done = 0;
  int           m_t    = 0;
  logic [127:0] m_key  = '0;
  logic [127:0] m_ct   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_done = 0; m_t = 0; m_key = '0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_busy = 1; m_t = 0; m_key = bus.in_key;
        m_ct = model_ct(bus.in_text, bus.in_key, ks_mode, rnd_mode);
      end
    end else if (!m_done) begin
      m_t++;
      if (m_t == N + 4) m_done = 1;
    end else if (bus.out_ready) begin
      m_busy = 0; m_done = 0;
    end
  end

  function automatic logic [4:0] exp_sk(input int t, input bit b, input bit d);
    if (!b || d)        exp_sk = 5'd0;
    else if (t == 0)    exp_sk = 5'd0;
    else if (t == 1)    exp_sk = 5'd1;
    else if (t <= N+1)  exp_sk = 5'(4 + t - 2);
    else if (t == N+2)  exp_sk = 5'd2;
    else                exp_sk = 5'd3;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready",  128'(bus.in_ready),  128'(!m_busy));
      chk("busy",      128'(busy),          128'(m_busy));
      chk("out_valid", 128'(bus.out_valid), 128'(m_done));
      chk("sk_sel",    128'(sk_sel),        128'(exp_sk(m_t, m_busy, m_done)));
      chk("rnd_en",    128'(rnd_en),        128'(m_busy && !m_done && m_t >= 2 && m_t <= N+1));
      chk("key_q",     key_q,               m_key);
      if (m_done) begin
        chk("out_text", bus.out_text, m_ct);
        chk("rnd_r",    {rnd_r0, rnd_r1, rnd_r2, rnd_r3}, m_ct);
      end
    end
  end

  logic [4:0] tr [0:63];
  int         en_cnt;

  // Offer one block from an idle DUT; returns edges from accept to out_valid (0 on timeout).
  task automatic send(input logic [127:0] t, input logic [127:0] k, output int lat);
    int g;
    g = 0;
    lat = 0;
    while (!bus.in_ready && g < 100) begin @(posedge clk); #1; g++; end
    if (!bus.in_ready) begin fail_now("send_in_ready"); return; end
    bus.in_valid = 1'b1; bus.in_text = t; bus.in_key = k;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    tr[0] = sk_sel;
    en_cnt = int'(rnd_en);
    for (int i = 1; i < 60; i++) begin
      @(posedge clk); #1;
      tr[i] = sk_sel;
      en_cnt += int'(rnd_en);
      if (bus.out_valid) begin lat = i; break; end
    end
    if (lat == 0) fail_now("send_out_valid");
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt, tx, kk, held, exp1;
    int lat, g;
    pt = 128'h00112233_44556677_8899AABB_CCDDEEFF;
`ifdef TWOFISH_FINAL_SWAP_EN
    exp1 = 128'h8899AABB_CCDDEEFF_00112233_44556677;
`else
    exp1 = pt;
`endif
    bus.in_valid = 0; bus.in_text = '0; bus.in_key = '0; bus.out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_busy",      128'(busy),          128'd0);
    chk("rst_key_q",     key_q,               128'd0);
    chk("rst_sk_sel",    128'(sk_sel),        128'd0);
    chk("rst_out_text",  bus.out_text,        128'd0);
    rst = 0;
    #1;
    chk("rst_in_ready",  128'(bus.in_ready),  128'd1);

    // Pure swap, zero subkeys: sk_sel trace, rnd_en count, latency, final swap ordering.
    chk("model_swap_pin", model_ct(pt, '0, 0, 0), exp1);
    send(pt, 128'h1, lat);
    chk("latency_swap", 128'(lat), 128'd20);
    chk("ct_swap", bus.out_text, exp1);
    for (int i = 0; i <= N + 4; i++) begin
      int e;
      e = (i == 0) ? 0 : (i == 1) ? 1 : (i <= N + 1) ? i + 2 : (i == N + 2) ? 2 : (i == N + 3) ? 3 : 0;
      chk($sformatf("sk_trace[%0d]", i), 128'(tr[i]), 128'(e));
    end
    chk("rnd_en_cycles", 128'(en_cnt), 128'(N));

    // Back-pressure in DONE.
    held = bus.out_text;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 128'(bus.out_valid), 128'd1);
      chk("hold_text",  bus.out_text,        held);
      chk("hold_ready", 128'(bus.in_ready),  128'd0);
    end
    release_out();
    chk("idle_in_ready",  128'(bus.in_ready),  128'd1);
    chk("idle_out_valid", 128'(bus.out_valid), 128'd0);

    // Whitening cancels.
    ks_mode = 1;
    chk("model_a5_pin", model_ct('0, '0, 1, 0), 128'd0);
    send('0, 128'h2, lat);
    chk("latency_a5", 128'(lat), 128'd20);
    chk("ct_a5", bus.out_text, 128'd0);
    release_out();

    // Output whitening differs from input whitening.
    ks_mode = 2;
    chk("model_5a_pin", model_ct('0, '0, 2, 0), {4{32'h5A5A5A5A}});
    send('0, 128'h3, lat);
    chk("ct_5a", bus.out_text, {4{32'h5A5A5A5A}});
    release_out();

    // Async reset in the middle of ROUND at cnt = 7.
    ks_mode = 3; rnd_mode = 1;
    tx = {$urandom, $urandom, $urandom, $urandom};
    kk = {$urandom, $urandom, $urandom, $urandom};
    bus.in_valid = 1; bus.in_text = tx; bus.in_key = kk;
    @(posedge clk); #1;
    bus.in_valid = 0;
    g = 0;
    while (sk_sel != 5'd11 && g < 40) begin @(posedge clk); #1; g++; end
    if (sk_sel != 5'd11) fail_now("wait_cnt7");
    rst = 1;
    #1;
    chk("mid_rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("mid_rst_busy",      128'(busy),          128'd0);
    chk("mid_rst_sk_sel",    128'(sk_sel),        128'd0);
    chk("mid_rst_key_q",     key_q,               128'd0);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'd1);
    tx = {$urandom, $urandom, $urandom, $urandom};
    kk = {$urandom, $urandom, $urandom, $urandom};
    send(tx, kk, lat);
    chk("latency_post_rst", 128'(lat), 128'd20);
    chk("ct_post_rst", bus.out_text, model_ct(tx, kk, 3, 1));
    release_out();

    // Random traffic against the per-cycle model.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = ($urandom % 2) == 0;
      bus.in_text   = {$urandom, $urandom, $urandom, $urandom};
      bus.in_key    = {$urandom, $urandom, $urandom, $urandom};
      bus.out_ready = ($urandom % 3) == 0;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (30) @(posedge clk);
    #1;
    chk("drain_idle", 128'(busy), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
